// File: rtl/calc_pkg.sv
// Shared constants for the seven-segment scan capture: active-low segment
// patterns (index 0 = a ... 6 = g), special digit codes, and FSM state type.
package calc_pkg;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_MINUS = 7'b1111110;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;
  localparam logic [3:0] CODE_ERR   = 4'hF;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of an active-low seven-segment pattern into a digit
// code; unrecognised patterns yield CODE_ERR with invalid raised.
module seg7_decode
  import calc_pkg::*;
(
  input  logic [0:6] pat,
  output logic [3:0] code,
  output logic       invalid
);

  always_comb begin
    code    = CODE_ERR;
    invalid = 1'b0;
    case (pat)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_MINUS: code = CODE_MINUS;
      SEG_BLANK: code = CODE_BLANK;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a 4-digit multiplexed seven-segment display scan into stable,
// atomically updated digit codes with glitch filtering and frame timeout.
module seg_scan_capture
  import calc_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:6] seg,
  input  logic [0:4] en,
  output logic [0:3] dig0,
  output logic [0:3] dig1,
  output logic [0:3] dig2,
  output logic [0:3] dig3,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       en_err,
  output logic       stale
);

  localparam int SW = (SETTLE  < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [0:6]          seg_s1, seg_s2;
  logic [0:4]          en_s1, en_s2;
  logic [SW-1:0]       scnt;
  logic [TW-1:0]       tcnt;
  logic                chg, settled, accept, multi;
  logic [2:0]          nlow;
  logic [1:0]          idx;
  logic [3:0]          dcode;
  logic                dinv;
  logic [3:0]          mask, mask_nxt;
  logic [3:0][3:0]     shadow;
  logic                complete, tmo;
  state_t              state, nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      en_s1  <= '1;
      en_s2  <= '1;
    end else begin
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      en_s1  <= en;
      en_s2  <= en_s1;
    end
  end

  // s1 differing from s2 means the synchronized value changes on this edge,
  // so the counter tracks how long seg_s2/en_s2 have held still.
  assign chg = (seg_s1 != seg_s2) || (en_s1 != en_s2);

  always_ff @(posedge clk) begin
    if (!rst_n)                  scnt <= '0;
    else if (chg)                scnt <= '0;
    else if (scnt != SW'(SETTLE)) scnt <= scnt + 1'b1;
  end

  // Fires exactly once per stable window, on the edge that completes SETTLE cycles.
  assign settled = (scnt == SW'(SETTLE - 1));

  always_comb begin
    nlow = '0;
    idx  = '0;
    for (int i = 0; i < 4; i++) begin
      if (!en_s2[i]) begin
        nlow = nlow + 3'd1;
        idx  = 2'(i);
      end
    end
  end

  assign accept = settled && (nlow == 3'd1);
  assign multi  = settled && (nlow >= 3'd2);

  seg7_decode u_dec (
    .pat     (seg_s2),
    .code    (dcode),
    .invalid (dinv)
  );

  assign complete = (state == ST_COLLECT) && (mask == 4'hF);
  assign tmo      = (state == ST_COLLECT) && !complete && !accept &&
                    (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (accept) nxt = ST_COLLECT;
      ST_COLLECT: begin
        if (complete)  nxt = accept ? ST_COLLECT : ST_IDLE;
        else if (tmo)  nxt = ST_IDLE;
      end
      default:    nxt = ST_IDLE;
    endcase
  end

  // An accept landing on the completion cycle seeds the next frame.
  always_comb begin
    mask_nxt = mask;
    if (complete || tmo) mask_nxt = '0;
    if (accept)          mask_nxt[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask   <= '0;
      tcnt   <= '0;
      shadow <= '0;
    end else begin
      mask <= mask_nxt;
      if (accept || nxt != ST_COLLECT) tcnt <= '0;
      else                             tcnt <= tcnt + 1'b1;
      if (accept) shadow[idx] <= dcode;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig0        <= CODE_BLANK;
      dig1        <= CODE_BLANK;
      dig2        <= CODE_BLANK;
      dig3        <= CODE_BLANK;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      en_err      <= 1'b0;
      stale       <= 1'b0;
    end else begin
      frame_valid <= complete;
      if (complete) begin
        dig0 <= shadow[0];
        dig1 <= shadow[1];
        dig2 <= shadow[2];
        dig3 <= shadow[3];
      end
      if (complete)   stale <= 1'b0;
      else if (tmo)   stale <= 1'b1;
      if (accept && dinv) seg_err <= 1'b1;
      if (multi)          en_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboarded bench for seg_scan_capture: stimulus pushes expected frames,
// a negedge monitor pops and compares whenever frame_valid pulses.
module tb_seg_scan_capture;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 300;

  localparam logic [0:6] P0 = 7'b0000001;
  localparam logic [0:6] P1 = 7'b1001111;
  localparam logic [0:6] P2 = 7'b0010010;
  localparam logic [0:6] P3 = 7'b0000110;
  localparam logic [0:6] P4 = 7'b1001100;
  localparam logic [0:6] P5 = 7'b0100100;
  localparam logic [0:6] P6 = 7'b0100000;
  localparam logic [0:6] P7 = 7'b0001111;
  localparam logic [0:6] P8 = 7'b0000000;
  localparam logic [0:6] P9 = 7'b0000100;
  localparam logic [0:6] PBAD = 7'b0110110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:6] seg;
  logic [0:4] en;
  logic [0:3] dig0, dig1, dig2, dig3;
  logic       frame_valid, seg_err, en_err, stale;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int t_start = 0;
  int fv_cyc  = -1;
  logic [15:0] expq[$];

  seg_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .en          (en),
    .dig0        (dig0),
    .dig1        (dig1),
    .dig2        (dig2),
    .dig3        (dig3),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .en_err      (en_err),
    .stale       (stale)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cyc = cyc;
      n_chk++;
      if (expq.size() == 0) begin
        $display("FAIL unexpected_frame: got %h expected no frame_valid", {dig0, dig1, dig2, dig3});
      end else begin
        logic [15:0] e;
        e = expq.pop_front();
        if ({dig0, dig1, dig2, dig3} == e) n_pass++;
        else $display("FAIL frame_digits: got %h expected %h", {dig0, dig1, dig2, dig3}, e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic show(input int d, input logic [0:6] p, input int n);
    @(negedge clk);
    seg = p;
    en = 5'b11111;
    en[d] = 1'b0;
    t_start = cyc;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    seg = 7'b1111111;
    en = 5'b11111;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic scan3(input logic [0:6] a, input logic [0:6] b, input logic [0:6] c);
    show(0, a, 100);
    show(1, b, 100);
    show(2, c, 100);
  endtask

  initial begin
    rst_n = 1'b0;
    seg = 7'b1111111;
    en = 5'b11111;
    repeat (3) @(negedge clk);
    chk("reset_digits", {dig0, dig1, dig2, dig3}, 16'hBBBB);
    chk("reset_flags", {frame_valid, seg_err, en_err, stale}, 4'b0000);
    rst_n = 1'b1;

    // Basic scan 1,2,3,4 and completion latency on the last digit
    expq.push_back(16'h1234);
    scan3(P1, P2, P3);
    show(3, P4, 100);
    chk("latency", fv_cyc - t_start, 2 + SETTLE + 1);
    idle(20);
    chk("scan_no_errs", {seg_err, en_err, stale}, 3'b000);
    chk("scan_digits_hold", {dig0, dig1, dig2, dig3}, 16'h1234);

    // Undecodable pattern on digit 2
    expq.push_back(16'h56F8);
    show(0, P5, 100);
    show(1, P6, 100);
    show(2, PBAD, 100);
    show(3, P8, 100);
    idle(20);
    chk("seg_err_set", seg_err, 1'b1);
    chk("en_err_clear", en_err, 1'b0);

    // Glitch: digit 0 held only SETTLE-1 cycles must not count
    show(0, P7, SETTLE - 1);
    idle(20);
    show(1, P7, 100);
    show(2, P8, 100);
    show(3, P9, 100);
    idle(20);
    chk("glitch_no_update", {dig0, dig1, dig2, dig3}, 16'h56F8);
    expq.push_back(16'h0789);
    show(0, P0, 100);
    idle(20);
    chk("glitch_then_frame", {dig0, dig1, dig2, dig3}, 16'h0789);

    // Two enables low together
    @(negedge clk);
    seg = P1;
    en = 5'b00111;
    repeat (9) @(negedge clk);
    idle(20);
    chk("en_err_set", en_err, 1'b1);
    chk("en_err_no_update", {dig0, dig1, dig2, dig3}, 16'h0789);

    // Partial frame then timeout
    scan3(P1, P2, P3);
    chk("stale_before_tmo", stale, 1'b0);
    idle(TIMEOUT + 1);
    chk("stale_set", stale, 1'b1);
    chk("tmo_digits_kept", {dig0, dig1, dig2, dig3}, 16'h0789);
    expq.push_back(16'h4567);
    show(0, P4, 100);
    show(1, P5, 100);
    show(2, P6, 100);
    show(3, P7, 100);
    idle(20);
    chk("stale_cleared", stale, 1'b0);

    // Reset mid-frame discards the partial frame
    scan3(P9, P8, P7);
    idle(5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_digits", {dig0, dig1, dig2, dig3}, 16'hBBBB);
    chk("midrst_flags", {frame_valid, seg_err, en_err, stale}, 4'b0000);
    show(3, P1, 100);
    idle(20);
    chk("midrst_no_frame", {dig0, dig1, dig2, dig3}, 16'hBBBB);
    expq.push_back(16'h3141);
    show(0, P3, 100);
    show(1, P1, 100);
    show(2, P4, 100);
    idle(20);
    chk("fresh_frame", {dig0, dig1, dig2, dig3}, 16'h3141);

    chk("scoreboard_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
